seg_scan_display: RTL and testbench
===================================

Name: seg_scan_display

Overview:
Parametrised multi-digit 7-segment driver for the traffic-light countdown and general numeric readouts.
- Converts a DATA_W-bit binary value to DIGITS BCD digits with a sequential shift-add-3 (double-dabble) engine.
- Holds the result in a shadow register.
- Time-multiplexes the digits onto one shared segment bus with a one-hot digit select.
- Replaces per-digit combinational divide/modulo, so digit count and input width scale freely.

Parameters:
DATA_W, 8, binary input width (>=4)
DIGITS, 3, number of displayed digits (1..8); digit 0 = units
SCAN_DIV, 50000, sys_clk cycles per digit slot (>=2)

Ports:
sys_clk  in  1  system clock, rising edge
sys_rst_n  in  1  asynchronous active-low reset
data_in  in  DATA_W  binary value to display
load  in  1  1-cycle request to convert data_in
busy  out  1  high while conversion is in progress
done  out  1  1-cycle pulse when a new value is committed to the display
ovf  out  1  high while the committed value exceeds 10^DIGITS-1
seg  out  7  segment bus {g,f,e,d,c,b,a}, 1 = lit
sel  out  DIGITS  digit select, one-hot active-low

Interface rule: one clock; reset is asynchronous and active-low, ports sys_clk / sys_rst_n.

Behaviour:
- Reset values: busy=0, done=0, ovf=0, seg=0, sel=all ones, shadow BCD=0, scan index=0, prescaler=0, FSM=IDLE.
- FSM IDLE -> CONV when load=1 in IDLE:
  - capture data_in into the shift register and clear the BCD accumulator;
  - capture ovf_next = (data_in > 10^DIGITS-1), with the limit computed as a localparam;
  - busy=1 from the next cycle.
- CONV runs exactly DATA_W cycles. Each cycle:
  - every BCD nibble >=5 gets +3;
  - the whole {bcd, shift} register shifts left by 1.
- CONV -> COMMIT after the DATA_W-th shift.
- COMMIT, one cycle:
  - shadow BCD <= accumulator and ovf <= ovf_next;
  - done=1, busy=0;
  - next state IDLE.
- Latency: load in cycle 0 -> done high in cycle DATA_W+1; new digits appear on seg from the following digit slot.
- load while busy is ignored; no queuing.
- load in the COMMIT cycle is also ignored.
- The display shows the old shadow value throughout conversion; no flicker or partial values.
- Overflow:
  - BCD bits beyond DIGITS*4 are discarded;
  - while ovf=1, every digit shows "-" (7'h40).
- Scan:
  - prescaler counts 0..SCAN_DIV-1 and issues a tick at SCAN_DIV-1;
  - each tick advances the scan index 0..DIGITS-1, wrapping to 0.
- seg and sel are registered and update together on the cycle after the tick, so no ghosting.
- First select after reset: digit 0, SCAN_DIV cycles after reset release.
- Decoder map: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F. Nibble codes 10-15 never occur; decode them to 0 (blank).
- DIGITS=1: sel is constant 0 after the first tick.
- Reset mid-conversion: abort immediately to the reset values; no done pulse.

Optional Feature:
LEADING_ZERO_BLANK_EN
- Defined: zero digits above the most significant non-zero digit drive seg=0.
  - Digit 0 is never blanked, so value 0 shows "0".
  - No effect while ovf=1.
- Undefined: all digits are shown, including leading zeros.

Decomposition:
- Package seg_disp_pkg holds the segment constants (SEG_0..SEG_9, SEG_DASH, SEG_OFF) and a function for the power-of-ten limit.
- One natural sub-module: seg7_decode (4-bit BCD -> 7-bit seg), combinational.
- The FSM, double-dabble datapath and scan logic stay in the top module.

Test Plan (DATA_W=8, DIGITS=3, SCAN_DIV=4 unless stated):
- Reset:
  - hold sys_rst_n=0 -> sel=3'b111, seg=0, busy=0, ovf=0;
  - release -> first sel=3'b110 with seg=7'h3F (or 0 with LEADING_ZERO_BLANK_EN for digits 1-2).
- Conversion: load with data_in=59 -> busy for 8 cycles, done in cycle 9; then digit0=7'h6F, digit1=7'h6D, digit2=7'h3F (7'h00 with the blank macro).
- Overflow: DIGITS=2, load with data_in=255 -> ovf=1, both digits show 7'h40; then load 42 -> ovf=0, digits 7'h5B / 7'h66.
- Busy rejection: load 200, then load 7 three cycles later -> only one done pulse, display shows 200 (7'h3F, 7'h3F, 7'h5B).
- Scan wrap: observe 12 ticks -> sel sequence 110, 101, 011 repeating; the digit changes exactly every 4 cycles.
- Reset mid-conversion: assert sys_rst_n=0 at CONV cycle 4 -> busy=0 asynchronously, no done pulse; after release the display shows 0.

Source files
------------

// File: rtl/seg_scan_display_pkg.sv
// Shared constants for the multiplexed 7-segment display driver:
// segment patterns, the conversion FSM state type and the
// power-of-ten limit used for overflow detection.
package seg_disp_pkg;

    // Segment patterns, bit order {g,f,e,d,c,b,a}, 1 = lit
    localparam logic [6:0] SEG_0    = 7'h3F;
    localparam logic [6:0] SEG_1    = 7'h06;
    localparam logic [6:0] SEG_2    = 7'h5B;
    localparam logic [6:0] SEG_3    = 7'h4F;
    localparam logic [6:0] SEG_4    = 7'h66;
    localparam logic [6:0] SEG_5    = 7'h6D;
    localparam logic [6:0] SEG_6    = 7'h7D;
    localparam logic [6:0] SEG_7    = 7'h07;
    localparam logic [6:0] SEG_8    = 7'h7F;
    localparam logic [6:0] SEG_9    = 7'h6F;
    localparam logic [6:0] SEG_DASH = 7'h40;
    localparam logic [6:0] SEG_OFF  = 7'h00;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CONV   = 2'd1,
        ST_COMMIT = 2'd2
    } conv_state_t;

    // Largest value representable with the given number of decimal digits
    function automatic longint unsigned pow10_limit(input int digits);
        longint unsigned p;
        p = 1;
        for (int i = 0; i < digits; i++) begin
            p = p * 10;
        end
        return p - 1;
    endfunction

endpackage

// File: rtl/seg_scan_display_if.sv
// Request/status bundle of the 7-segment display driver.
// master = the client that requests conversions, slave = the driver.
interface seg_scan_display_if #(
    parameter int DATA_W = 8,
    parameter int DIGITS = 3
);
    logic [DATA_W-1:0] data_in;
    logic              load;
    logic              busy;
    logic              done;
    logic              ovf;
    logic [6:0]        seg;
    logic [DIGITS-1:0] sel;

    modport master (
        output data_in, load,
        input  busy, done, ovf, seg, sel
    );

    modport slave (
        input  data_in, load,
        output busy, done, ovf, seg, sel
    );
endinterface

// File: rtl/seg_scan_display_seg7_decode.sv
// BCD digit to 7-segment pattern. Codes 10..15 cannot come out of the
// double-dabble engine; they decode to a blank digit.
module seg7_decode
    import seg_disp_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    // Plain lookup of the digit pattern
    always_comb begin
        seg = SEG_OFF;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/seg_scan_display.sv
// Multi-digit 7-segment scan driver. A load converts data_in to BCD with a
// sequential shift-add-3 engine (DATA_W cycles), commits the digits to a
// shadow register and the scanner time-multiplexes them onto one segment bus.
// Optional build macro: LEADING_ZERO_BLANK_EN blanks zero digits above the
// most significant non-zero digit.
module seg_scan_display
    import seg_disp_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int DIGITS   = 3,
    parameter int SCAN_DIV = 50000
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    seg_scan_display_if.slave bus
);

    localparam int              BCD_W     = 4 * DIGITS;
    localparam int              DD_W      = BCD_W + DATA_W;
    localparam longint unsigned OVF_LIMIT = pow10_limit(DIGITS);
    localparam int              CNT_W     = $clog2(DATA_W + 1);
    localparam int              PRE_W     = $clog2(SCAN_DIV);
    localparam int              IDX_W     = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    conv_state_t       state, state_next;
    logic [CNT_W-1:0]  cnt_q;
    logic [DATA_W-1:0] shift_q;
    logic [BCD_W-1:0]  bcd_q;
    logic [BCD_W-1:0]  shadow_q;
    logic              ovf_next_q;
    logic              ovf_q;
    logic              busy;
    logic              done;
    logic              ovf_cmp;
    logic [DD_W-1:0]   dd_shift;

    logic [PRE_W-1:0]  presc_q;
    logic              tick;
    logic [IDX_W-1:0]  idx_q;
    logic [3:0]        cur_nib;
    logic              cur_blank;
    logic [6:0]        dec_seg;
    logic [6:0]        seg_next;
    logic [6:0]        seg_q;
    logic [DIGITS-1:0] sel_q;

    // Nibbles of 5 or more get +3 so the following left shift carries correctly.
    // Upper BCD digits beyond DIGITS are never stored: carries out of the kept
    // nibbles are simply lost, which only matters for overflowed values.
    function automatic logic [BCD_W-1:0] add3_all(input logic [BCD_W-1:0] b);
        logic [BCD_W-1:0] r;
        r = b;
        for (int i = 0; i < DIGITS; i++) begin
            if (r[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = r[4*i +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

    assign ovf_cmp  = ({{64{1'b0}}, bus.data_in} > {{DATA_W{1'b0}}, OVF_LIMIT});
    assign dd_shift = {add3_all(bcd_q), shift_q} << 1;

    // FSM state register
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next state: loads are accepted only in IDLE
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:   if (bus.load) state_next = ST_CONV;
            ST_CONV:   if (cnt_q == CNT_W'(DATA_W - 1)) state_next = ST_COMMIT;
            ST_COMMIT: state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state)
            ST_CONV:   busy = 1'b1;
            ST_COMMIT: done = 1'b1;
            default:   ;
        endcase
    end

    // Conversion control: shift counter and overflow flag captured at load
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt_q      <= '0;
            ovf_next_q <= 1'b0;
        end else if (state == ST_IDLE && bus.load) begin
            cnt_q      <= '0;
            ovf_next_q <= ovf_cmp;
        end else if (state == ST_CONV) begin
            cnt_q      <= cnt_q + CNT_W'(1);
        end
    end

    // Double-dabble datapath: load clears the BCD part, CONV adjusts and shifts
    always_ff @(posedge sys_clk) begin
        if (state == ST_IDLE && bus.load) begin
            shift_q <= bus.data_in;
            bcd_q   <= '0;
        end else if (state == ST_CONV) begin
            shift_q <= dd_shift[DATA_W-1:0];
            bcd_q   <= dd_shift[DD_W-1:DATA_W];
        end
    end

    // Commit: the display only ever sees complete results
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            shadow_q <= '0;
            ovf_q    <= 1'b0;
        end else if (state == ST_COMMIT) begin
            shadow_q <= bcd_q;
            ovf_q    <= ovf_next_q;
        end
    end

    // Scan prescaler, one tick per digit slot
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            presc_q <= '0;
        end else if (tick) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_q + PRE_W'(1);
        end
    end

    assign tick = (presc_q == PRE_W'(SCAN_DIV - 1));

    // Scan index wraps over the populated digits
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            idx_q <= '0;
        end else if (tick) begin
            if (idx_q == IDX_W'(DIGITS - 1)) begin
                idx_q <= '0;
            end else begin
                idx_q <= idx_q + IDX_W'(1);
            end
        end
    end

    // Select the nibble of the digit being scanned
    always_comb begin
        cur_nib = 4'd0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                cur_nib = shadow_q[4*i +: 4];
            end
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    // A digit is blank when it and every digit above it are zero; digit 0 never is
    always_comb begin
        logic above_zero;
        above_zero = 1'b1;
        cur_blank  = 1'b0;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            above_zero = above_zero && (shadow_q[4*i +: 4] == 4'd0);
            if (idx_q == IDX_W'(i)) begin
                cur_blank = above_zero;
            end
        end
    end
`else
    assign cur_blank = 1'b0;
`endif

    seg7_decode u_dec (
        .bcd (cur_nib),
        .seg (dec_seg)
    );

    assign seg_next = ovf_q ? SEG_DASH : (cur_blank ? SEG_OFF : dec_seg);

    // Segment and select registered together on the tick so they never disagree
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            seg_q <= SEG_OFF;
            sel_q <= '1;
        end else if (tick) begin
            seg_q <= seg_next;
            sel_q <= ~(DIGITS'(1) << idx_q);
        end
    end

    assign bus.busy = busy;
    assign bus.done = done;
    assign bus.ovf  = ovf_q;
    assign bus.seg  = seg_q;
    assign bus.sel  = sel_q;

endmodule

// File: tb/tb_seg_scan_display.sv
// Bench for seg_scan_display: a 3-digit and a 2-digit instance (DATA_W=8,
// SCAN_DIV=4) driven with directed and random values, compared against a
// decimal-arithmetic model of what each digit must show.
module tb_seg_scan_display;

    localparam int DW = 8;
    localparam int SD = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    seg_scan_display_if #(.DATA_W(DW), .DIGITS(3)) bus3 ();
    seg_scan_display_if #(.DATA_W(DW), .DIGITS(2)) bus2 ();

    seg_scan_display #(.DATA_W(DW), .DIGITS(3), .SCAN_DIV(SD)) dut3 (
        .sys_clk   (clk),
        .sys_rst_n (rst_n),
        .bus       (bus3.slave)
    );

    seg_scan_display #(.DATA_W(DW), .DIGITS(2), .SCAN_DIV(SD)) dut2 (
        .sys_clk   (clk),
        .sys_rst_n (rst_n),
        .bus       (bus2.slave)
    );

    logic [6:0] seg_tbl [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    // What digit i of an nd-digit display must show for value v
    function automatic logic [6:0] model_seg(input int v, input int nd, input int i);
        int lim;
        int p;
        lim = 1;
        p   = 1;
        for (int k = 0; k < nd; k++) lim = lim * 10;
        for (int k = 0; k < i; k++) p = p * 10;
        if (v > lim - 1) return 7'h40;
`ifdef LEADING_ZERO_BLANK_EN
        if (i > 0 && (v / p) == 0) return 7'h00;
`endif
        return seg_tbl[(v / p) % 10];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One-cycle load pulse; returns one cycle after the sampling edge
    task automatic start_load(input bit d2, input int v);
        if (d2) begin bus2.data_in = 8'(v); bus2.load = 1'b1; end
        else    begin bus3.data_in = 8'(v); bus3.load = 1'b1; end
        step();
        bus2.load = 1'b0;
        bus3.load = 1'b0;
    endtask

    // Cycle index (1 = first cycle after load edge) of done, -1 if none
    task automatic wait_done(input bit d2, input int maxc, output int lat);
        lat = -1;
        for (int c = 1; c <= maxc; c++) begin
            if (d2 ? bus2.done : bus3.done) begin
                lat = c;
                break;
            end
            step();
        end
    endtask

    // Let one full scan pass, then record what each digit slot shows
    task automatic capture(input bit d2, output logic [2:0][6:0] s, output bit ok);
        logic [2:0] seen;
        logic [2:0] sv;
        logic [6:0] sg;
        s    = '0;
        seen = d2 ? 3'b100 : 3'b000;
        repeat (12) step();
        for (int c = 0; c < 16; c++) begin
            sv = d2 ? {1'b1, bus2.sel} : bus3.sel;
            sg = d2 ? bus2.seg : bus3.seg;
            for (int i = 0; i < 3; i++) begin
                if (sv == ~(3'b001 << i)) begin
                    s[i]    = sg;
                    seen[i] = 1'b1;
                end
            end
            step();
        end
        ok = (seen == 3'b111);
    endtask

    task automatic test_reset();
        int n;
        rst_n = 1'b0;
        repeat (3) step();
        checks++; if (bus3.sel !== 3'b111) begin errors++; $display("FAIL reset_sel3 got %b want 111", bus3.sel); end
        checks++; if (bus2.sel !== 2'b11) begin errors++; $display("FAIL reset_sel2 got %b want 11", bus2.sel); end
        checks++; if (bus3.seg !== 7'h00) begin errors++; $display("FAIL reset_seg got %h want 00", bus3.seg); end
        checks++; if ({bus3.busy, bus3.done, bus3.ovf} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b want 000", {bus3.busy, bus3.done, bus3.ovf}); end
        rst_n = 1'b1;
        n = 0;
        for (int c = 1; c <= 20; c++) begin
            step();
            n = c;
            if (bus3.sel !== 3'b111) break;
        end
        checks++; if (n != SD) begin errors++; $display("FAIL first_sel_delay got %0d want %0d", n, SD); end
        checks++; if (bus3.sel !== 3'b110) begin errors++; $display("FAIL first_sel got %b want 110", bus3.sel); end
        checks++; if (bus3.seg !== model_seg(0, 3, 0)) begin errors++; $display("FAIL first_seg got %h want %h", bus3.seg, model_seg(0, 3, 0)); end
        repeat (SD) step();
        checks++; if (bus3.sel !== 3'b101) begin errors++; $display("FAIL second_sel got %b want 101", bus3.sel); end
        checks++; if (bus3.seg !== model_seg(0, 3, 1)) begin errors++; $display("FAIL second_seg got %h want %h", bus3.seg, model_seg(0, 3, 1)); end
    endtask

    task automatic test_conversion();
        int nb;
        int nd;
        int lat;
        logic [2:0][6:0] s;
        bit ok;
        start_load(1'b0, 59);
        nb = 0; nd = 0; lat = -1;
        for (int c = 1; c <= 20; c++) begin
            if (bus3.busy) nb++;
            if (bus3.done) begin
                nd++;
                if (lat < 0) lat = c;
            end
            step();
        end
        checks++; if (lat != DW + 1) begin errors++; $display("FAIL conv_latency got %0d want %0d", lat, DW + 1); end
        checks++; if (nb != DW) begin errors++; $display("FAIL conv_busy_cycles got %0d want %0d", nb, DW); end
        checks++; if (nd != 1) begin errors++; $display("FAIL conv_done_pulses got %0d want 1", nd); end
        capture(1'b0, s, ok);
        checks++; if (!ok) begin errors++; $display("FAIL conv_scan_seen got 0 want 1"); end
        for (int i = 0; i < 3; i++) begin
            checks++; if (s[i] !== model_seg(59, 3, i)) begin errors++; $display("FAIL conv59_digit%0d got %h want %h", i, s[i], model_seg(59, 3, i)); end
        end
    endtask

    task automatic test_random();
        int v;
        int lat;
        logic [2:0][6:0] s;
        bit ok;
        bit d2;
        int nd;
        for (int t = 0; t < 10; t++) begin
            d2 = (t >= 6);
            nd = d2 ? 2 : 3;
            v  = int'($urandom_range(0, 255));
            start_load(d2, v);
            wait_done(d2, 20, lat);
            checks++; if (lat != DW + 1) begin errors++; $display("FAIL rand_latency v=%0d got %0d want %0d", v, lat, DW + 1); end
            capture(d2, s, ok);
            checks++; if (!ok) begin errors++; $display("FAIL rand_scan_seen v=%0d got 0 want 1", v); end
            checks++; if ((d2 ? bus2.ovf : bus3.ovf) !== (v > ((nd == 2) ? 99 : 999))) begin errors++; $display("FAIL rand_ovf v=%0d got %b want %b", v, d2 ? bus2.ovf : bus3.ovf, v > ((nd == 2) ? 99 : 999)); end
            for (int i = 0; i < nd; i++) begin
                checks++; if (s[i] !== model_seg(v, nd, i)) begin errors++; $display("FAIL rand_digit%0d v=%0d nd=%0d got %h want %h", i, v, nd, s[i], model_seg(v, nd, i)); end
            end
        end
    endtask

    task automatic test_overflow();
        int lat;
        logic [2:0][6:0] s;
        bit ok;
        start_load(1'b1, 255);
        wait_done(1'b1, 20, lat);
        capture(1'b1, s, ok);
        checks++; if (bus2.ovf !== 1'b1) begin errors++; $display("FAIL ovf_set got %b want 1", bus2.ovf); end
        checks++; if (s[0] !== 7'h40 || s[1] !== 7'h40) begin errors++; $display("FAIL ovf_dash got %h/%h want 40/40", s[0], s[1]); end
        start_load(1'b1, 42);
        wait_done(1'b1, 20, lat);
        capture(1'b1, s, ok);
        checks++; if (bus2.ovf !== 1'b0) begin errors++; $display("FAIL ovf_clear got %b want 0", bus2.ovf); end
        checks++; if (s[0] !== 7'h5B || s[1] !== 7'h66) begin errors++; $display("FAIL ovf_42 got %h/%h want 5B/66", s[0], s[1]); end
    endtask

    task automatic test_busy_reject();
        int nd;
        logic [2:0][6:0] s;
        bit ok;
        start_load(1'b0, 200);
        step();
        step();
        start_load(1'b0, 7);
        nd = 0;
        for (int c = 0; c < 25; c++) begin
            if (bus3.done) nd++;
            step();
        end
        checks++; if (nd != 1) begin errors++; $display("FAIL busy_done_pulses got %0d want 1", nd); end
        capture(1'b0, s, ok);
        checks++; if (s[0] !== 7'h3F || s[1] !== 7'h3F || s[2] !== 7'h5B) begin errors++; $display("FAIL busy_value got %h/%h/%h want 3F/3F/5B", s[0], s[1], s[2]); end
    endtask

    task automatic test_commit_ignore();
        int lat;
        logic [2:0][6:0] s;
        bit ok;
        start_load(1'b0, 5);
        wait_done(1'b0, 20, lat);
        checks++; if (lat != DW + 1) begin errors++; $display("FAIL commit_latency got %0d want %0d", lat, DW + 1); end
        start_load(1'b0, 9);
        checks++; if (bus3.busy !== 1'b0) begin errors++; $display("FAIL commit_load_busy got %b want 0", bus3.busy); end
        capture(1'b0, s, ok);
        checks++; if (s[0] !== model_seg(5, 3, 0)) begin errors++; $display("FAIL commit_value got %h want %h", s[0], model_seg(5, 3, 0)); end
    endtask

    task automatic test_scan_wrap();
        logic [2:0] prev;
        logic [2:0] vals [12];
        int gaps [12];
        int got;
        int cyc;
        prev = bus3.sel;
        got  = 0;
        cyc  = 0;
        for (int c = 0; c < 80 && got < 12; c++) begin
            step();
            cyc++;
            if (bus3.sel !== prev) begin
                vals[got] = bus3.sel;
                gaps[got] = cyc;
                cyc  = 0;
                prev = bus3.sel;
                got++;
            end
        end
        checks++; if (got != 12) begin errors++; $display("FAIL scan_ticks got %0d want 12", got); end
        checks++; if (vals[0] !== 3'b110 && vals[0] !== 3'b101 && vals[0] !== 3'b011) begin errors++; $display("FAIL scan_onehot got %b want one-hot-low", vals[0]); end
        for (int k = 1; k < got; k++) begin
            checks++; if (vals[k] !== {vals[k-1][1:0], vals[k-1][2]}) begin errors++; $display("FAIL scan_order k=%0d got %b want %b", k, vals[k], {vals[k-1][1:0], vals[k-1][2]}); end
            checks++; if (gaps[k] != SD) begin errors++; $display("FAIL scan_period k=%0d got %0d want %0d", k, gaps[k], SD); end
        end
    endtask

    task automatic test_reset_mid();
        int nd;
        logic [2:0][6:0] s;
        bit ok;
        start_load(1'b0, 123);
        repeat (3) step();
        checks++; if (bus3.busy !== 1'b1) begin errors++; $display("FAIL mid_busy_before got %b want 1", bus3.busy); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (bus3.busy !== 1'b0) begin errors++; $display("FAIL mid_busy_async got %b want 0", bus3.busy); end
        checks++; if (bus3.sel !== 3'b111) begin errors++; $display("FAIL mid_sel_async got %b want 111", bus3.sel); end
        step();
        step();
        rst_n = 1'b1;
        nd = 0;
        for (int c = 0; c < 20; c++) begin
            if (bus3.done) nd++;
            step();
        end
        checks++; if (nd != 0) begin errors++; $display("FAIL mid_done_pulses got %0d want 0", nd); end
        capture(1'b0, s, ok);
        for (int i = 0; i < 3; i++) begin
            checks++; if (s[i] !== model_seg(0, 3, i)) begin errors++; $display("FAIL mid_digit%0d got %h want %h", i, s[i], model_seg(0, 3, i)); end
        end
    endtask

    initial begin
        bus3.data_in = '0; bus3.load = 1'b0;
        bus2.data_in = '0; bus2.load = 1'b0;
        test_reset();
        test_conversion();
        test_random();
        test_overflow();
        test_busy_reject();
        test_commit_ignore();
        test_scan_wrap();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1);
    end

endmodule
